// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: stall/flush sequencing, EX forwarding selects, ID bypass and saturating hazard counters
module pipe_hazard_ctl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_wn,
  input  logic             mem_RegWrite,
  input  logic             wb_RegWrite,
  input  logic [4:0]       mem_wn,
  input  logic [4:0]       wb_wn,
  input  logic             mem_take,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             byp_a,
  output logic             byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, LU_STALL} state_t;
  state_t state, state_n;
  logic load_use, stall_ev, flush_ev;
  assign load_use = ex_MemRead && |ex_wn && (ex_wn == id_rs || (id_uses_rt && ex_wn == id_rt));
  // LU_STALL suppresses detection so each load inserts at most one bubble
  assign stall_ev = rst && !mem_take && state == RUN && load_use;
  assign flush_ev = rst && mem_take;
  always_comb begin
    state_n     = stall_ev ? LU_STALL : RUN;
    pc_en       = rst && !stall_ev;
    ifid_en     = rst && !stall_ev;
    ifid_flush  = !rst || mem_take;
    idex_flush  = !rst || mem_take || stall_ev;
    exmem_flush = !rst || mem_take;
    fwd_a = !rst ? 2'b00 : (mem_RegWrite && |mem_wn && mem_wn == ex_rs) ? 2'b10 :
            (wb_RegWrite && |wb_wn && wb_wn == ex_rs) ? 2'b01 : 2'b00;
    fwd_b = !rst ? 2'b00 : (mem_RegWrite && |mem_wn && mem_wn == ex_rt) ? 2'b10 :
            (wb_RegWrite && |wb_wn && wb_wn == ex_rt) ? 2'b01 : 2'b00;
    byp_a = rst && wb_RegWrite && |wb_wn && wb_wn == id_rs;
    byp_b = rst && wb_RegWrite && |wb_wn && wb_wn == id_rt;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb_pipe_hazard_ctl: directed and random checks against a cycle-level behavioural model
module tb_pipe_hazard_ctl;
  logic clk = 0;
  logic rst, id_uses_rt, ex_MemRead, mem_RegWrite, wb_RegWrite, mem_take;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wn, mem_wn, wb_wn;
  logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, byp_a, byp_b;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic pc_en_s, ifid_en_s, ifid_flush_s, idex_flush_s, exmem_flush_s, byp_a_s, byp_b_s;
  logic [1:0] fwd_a_s, fwd_b_s, stall_cnt_s, flush_cnt_s;
  int errors = 0, checks = 0;
  bit m_valid = 0, m_lu = 0;
  int m_stall = 0, m_flush = 0, m_stall_s = 0, m_flush_s = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_MemRead(ex_MemRead), .ex_wn(ex_wn),
    .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite), .mem_wn(mem_wn), .wb_wn(wb_wn),
    .mem_take(mem_take), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .byp_a(byp_a), .byp_b(byp_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_hazard_ctl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_MemRead(ex_MemRead), .ex_wn(ex_wn),
    .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite), .mem_wn(mem_wn), .wb_wn(wb_wn),
    .mem_take(mem_take), .pc_en(pc_en_s), .ifid_en(ifid_en_s), .ifid_flush(ifid_flush_s),
    .idex_flush(idex_flush_s), .exmem_flush(exmem_flush_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
    .byp_a(byp_a_s), .byp_b(byp_b_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] r);
    if (mem_RegWrite && mem_wn != 0 && mem_wn == r) return 2'b10;
    if (wb_RegWrite && wb_wn != 0 && wb_wn == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_MemRead = 0;
    ex_wn = 0; mem_RegWrite = 0; wb_RegWrite = 0; mem_wn = 0; wb_wn = 0; mem_take = 0;
  endtask

  task automatic cycle();
    bit hz, stall;
    logic [4:0] ctl;
    #1;
    hz = ex_MemRead && ex_wn != 0 && (ex_wn == id_rs || (id_uses_rt && ex_wn == id_rt));
    stall = rst && !mem_take && !m_lu && hz;
    ctl = !rst ? 5'b00111 : mem_take ? 5'b11111 : stall ? 5'b00010 : 5'b11000;
    chk("ctl", {11'd0, pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush}, {11'd0, ctl});
    chk("ctl_s", {11'd0, pc_en_s, ifid_en_s, ifid_flush_s, idex_flush_s, exmem_flush_s}, {11'd0, ctl});
    chk("fwd", {12'd0, fwd_a, fwd_b}, !rst ? 16'd0 : {12'd0, fwd_model(ex_rs), fwd_model(ex_rt)});
    chk("byp", {14'd0, byp_a, byp_b}, {14'd0,
        rst && wb_RegWrite && wb_wn != 0 && wb_wn == id_rs,
        rst && wb_RegWrite && wb_wn != 0 && wb_wn == id_rt});
    if (m_valid) begin
      chk("stall_cnt", stall_cnt, m_stall[15:0]);
      chk("flush_cnt", flush_cnt, m_flush[15:0]);
      chk("stall_cnt_s", {14'd0, stall_cnt_s}, m_stall_s[15:0]);
      chk("flush_cnt_s", {14'd0, flush_cnt_s}, m_flush_s[15:0]);
    end
    @(posedge clk);
    if (!rst) begin
      m_valid = 1; m_lu = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      m_lu = stall;
      if (stall) begin
        m_stall = m_stall < 65535 ? m_stall + 1 : m_stall;
        m_stall_s = m_stall_s < 3 ? m_stall_s + 1 : m_stall_s;
      end
      if (mem_take) begin
        m_flush = m_flush < 65535 ? m_flush + 1 : m_flush;
        m_flush_s = m_flush_s < 3 ? m_flush_s + 1 : m_flush_s;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle(); rst = 0;
    cycle(); cycle();
    idle(); cycle();
    ex_MemRead = 1; ex_wn = 8; id_rs = 8;
    cycle(); cycle(); cycle(); cycle();
    idle(); ex_MemRead = 1; ex_wn = 0; id_rs = 0; cycle();
    ex_wn = 9; id_rt = 9; id_uses_rt = 0; cycle();
    id_uses_rt = 1; cycle(); cycle();
    idle(); mem_wn = 5; wb_wn = 5; mem_RegWrite = 1; wb_RegWrite = 1; ex_rs = 5; ex_rt = 5; cycle();
    mem_RegWrite = 0; id_rt = 5; id_rs = 5; cycle();
    mem_wn = 0; wb_wn = 0; mem_RegWrite = 1; ex_rs = 0; id_rs = 0; cycle();
    idle(); ex_MemRead = 1; ex_wn = 7; id_rs = 7; mem_take = 1; cycle();
    mem_take = 0; cycle(); cycle();
    idle(); ex_MemRead = 1; ex_wn = 4; id_rt = 4; id_uses_rt = 1; cycle();
    rst = 0; cycle();
    idle(); cycle();
    mem_take = 1;
    repeat (5) cycle();
    idle(); cycle();
    repeat (400) begin
      rst = $urandom_range(0, 24) != 0;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_wn = 5'($urandom_range(0, 3)); mem_wn = 5'($urandom_range(0, 3));
      wb_wn = 5'($urandom_range(0, 3)); id_uses_rt = 1'($urandom);
      ex_MemRead = 1'($urandom); mem_RegWrite = 1'($urandom); wb_RegWrite = 1'($urandom);
      mem_take = $urandom_range(0, 5) == 0;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Hazard and sequencing controller for the 5-stage pipelined MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB registers; branch/jump resolved in MEM). Each cycle it decides PC and IF/ID enables and the bubble/flush controls for the pipeline registers. It also produces EX-stage operand forwarding selects, an ID-stage write-back bypass, and saturating stall/flush event counters. It sits beside the main control decoder and drives only enable, flush and mux-select lines; it holds no datapath values.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw)
- ex_rs, ex_rt  in  5 each  source register numbers held in ID/EX
- ex_MemRead  in  1  instruction in EX is a load
- ex_wn  in  5  destination register of the instruction in EX (after RegDst/jal mux)
- mem_RegWrite, wb_RegWrite  in  1 each  RegWrite of the EX/MEM and MEM/WB registers
- mem_wn, wb_wn  in  5 each  destination registers in EX/MEM and MEM/WB
- mem_take  in  1  branch taken or jump in MEM (PCSrc OR Jump)
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all controls 0) into that register on this edge
- fwd_a, fwd_b  out  2 each  EX ALU operand select: 00 register value, 10 EX/MEM alu_out, 01 WB write data
- byp_a, byp_b  out  1 each  ID read-port bypass: 1 selects WB write data in place of RD1/RD2
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- FSM states: RUN, LU_STALL. Reset state RUN.
- load_use = ex_MemRead AND ex_wn != 0 AND (ex_wn == id_rs OR (id_uses_rt AND ex_wn == id_rt)).
- Priority per cycle: redirect > load-use > normal.
- Redirect (mem_take=1, any state): pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, exmem_flush=1. Next state is RUN. flush_cnt increments.
- Load-use (state RUN, mem_take=0, load_use=1): pc_en=0, ifid_en=0, idex_flush=1, other flushes 0. Next state is LU_STALL. stall_cnt increments.
- LU_STALL with mem_take=0: pc_en=1, ifid_en=1, no flushes. load_use detection is suppressed, giving at most one bubble per load. Next state is RUN.
- Normal: pc_en=1, ifid_en=1, all flushes 0. State stays RUN.
- Forwarding for operand A:
  - fwd_a=10 if mem_RegWrite AND mem_wn != 0 AND mem_wn == ex_rs.
  - Otherwise fwd_a=01 if wb_RegWrite AND wb_wn != 0 AND wb_wn == ex_rs.
  - Otherwise fwd_a=00.
  - fwd_b is the same rule using ex_rt. MEM beats WB.
- ID bypass: byp_a = wb_RegWrite AND wb_wn != 0 AND wb_wn == id_rs. byp_b is the same rule using id_rt. This covers write-then-read in the same cycle.
- Register $0 never forwards and never causes a stall.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All outputs except the counters are combinational from the current inputs and state; there is no added latency.
- State and counters update on the rising edge of clk.
- While rst=0, the next edge loads: state RUN, stall_cnt=0, flush_cnt=0.
- During the rst=0 cycle itself, outputs are forced: pc_en=0, ifid_en=0, all flushes=1, fwd_a=fwd_b=00, byp_a=byp_b=0.
- Reset asserted mid-stall: LU_STALL is abandoned and no second bubble is issued after release.
- A load-use stall costs exactly one cycle. A redirect costs three squashed instructions, with the target fetched on the following cycle.
- mem_take together with load_use: redirect wins, stall_cnt is unchanged, and the next state is RUN.

## Test plan
- Reset: hold rst=0 for 2 cycles -> pc_en=0, all flushes=1, counters=0. One cycle after release with no hazards -> pc_en=1, flushes=0.
- Load-use: ex_MemRead=1, ex_wn=8, id_rs=8 -> cycle N: pc_en=0, ifid_en=0, idex_flush=1, stall_cnt 0→1. Cycle N+1 with the same inputs held -> pc_en=1, no bubble, state RUN.
- $0 and rt filter: ex_MemRead=1, ex_wn=0, id_rs=0 -> no stall. ex_wn=9, id_rt=9, id_uses_rt=0 -> no stall.
- Forwarding: mem_wn=wb_wn=5, both RegWrite=1, ex_rs=5 -> fwd_a=10. With mem_RegWrite=0 -> fwd_a=01. wb_wn=5, id_rt=5 -> byp_b=1.
- Redirect: mem_take=1 with load_use=1 at the same time -> all three flushes=1, pc_en=1, flush_cnt+1, stall_cnt unchanged, next state RUN.
- Saturation: CNT_W=2, apply 5 redirects -> flush_cnt reaches 3 and stays at 3.
